mul8_seq_ctrl: RTL and testbench



---
 rtl/mul8_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: four nibble passes through one shared 4x4 array multiplier.
// Optional `define MUL8_ZERO_BYPASS_EN retires zero-operand products after a single CALC edge with p=0.

module Multiplier_4bit (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic [7:0] o_p
);

  logic [4:0] w_rows [4];
  logic [3:0] w_pp;
  logic       w_carry;
  logic       w_sx;
  logic       w_sy;

  // Array multiplier: each row ripple-adds the next AND-gated partial product to the previous row.
  always_comb begin
    w_pp     = i_x & {4{i_y[0]}};
    w_rows[0] = {1'b0, w_pp};
    w_carry  = 1'b0;
    w_sx     = 1'b0;
    w_sy     = 1'b0;
    for (int r = 1; r < 4; r++) begin
      w_pp    = i_x & {4{i_y[r]}};
      w_carry = 1'b0;
      for (int k = 0; k < 4; k++) begin
        w_sx         = w_rows[r-1][k+1];
        w_sy         = w_pp[k];
        w_rows[r][k] = w_sx ^ w_sy ^ w_carry;
        w_carry      = (w_sx & w_sy) | (w_carry & (w_sx ^ w_sy));
      end
      w_rows[r][4] = w_carry;
    end
  end

  assign o_p = {w_rows[3], w_rows[2][0], w_rows[1][0], w_rows[0][0]};

endmodule

module mul8_seq_ctrl #(
  parameter bit HOLD_P = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_step;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [15:0] r_p;
  logic [3:0]  w_mulX;
  logic [3:0]  w_mulY;
  logic [7:0]  w_mulP;
  logic [15:0] w_accNext;
  logic        w_inCalc;
  logic        w_zeroOp;

`ifdef MUL8_ZERO_BYPASS_EN
  assign w_zeroOp = (r_a == 8'd0) || (r_b == 8'd0);
`else
  assign w_zeroOp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_nextState = CALC;
      end
      CALC: begin
        if (r_step == 2'd3 || w_zeroOp) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        busy        = 1'b0;
      end
    endcase
  end

  // step[0] selects the high nibble of a, step[1] the high nibble of b; outside CALC both stay on nibble 0.
  assign w_inCalc = (r_state == CALC);
  assign w_mulX   = (w_inCalc && r_step[0]) ? r_a[7:4] : r_a[3:0];
  assign w_mulY   = (w_inCalc && r_step[1]) ? r_b[7:4] : r_b[3:0];

  Multiplier_4bit u_mul (
    .i_x (w_mulX),
    .i_y (w_mulY),
    .o_p (w_mulP)
  );

  always_comb begin
    case (r_step)
      2'd0:    w_accNext = r_acc + {8'd0, w_mulP};
      2'd3:    w_accNext = r_acc + {w_mulP, 8'd0};
      default: w_accNext = r_acc + {4'd0, w_mulP, 4'd0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= 2'd0;
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_acc  <= 16'd0;
      r_p    <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= 16'd0;
            r_step <= 2'd0;
          end
        end
        CALC: begin
          if (w_zeroOp) begin
            r_p <= 16'd0;
          end else begin
            r_acc  <= w_accNext;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3) r_p <= w_accNext;
          end
        end
        DONE: begin
          if (out_ready && !HOLD_P) r_p <= 16'd0;
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Randomized self-checking bench for mul8_seq_ctrl against a plain-arithmetic product/latency model.
`timescale 1ns/1ps

module tb_mul8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;

   int checkCount = 0;
   int failCount  = 0;

   // Shift-and-add schedule: which nibble of a and b each step uses, and its weight.
   int stepAHi   [4] = '{0, 1, 0, 1};
   int stepBHi   [4] = '{0, 0, 1, 1};
   int stepShift [4] = '{0, 4, 4, 8};

   always #5 clk = ~clk;

   mul8_seq_ctrl #(.HOLD_P(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one full transaction and compare against the reference model.
   task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input int holdCycles);
      int unsigned product;
      int unsigned accModel;
      int unsigned an;
      int unsigned bn;
      bit bypass;
      product  = int'(opA) * int'(opB);
      accModel = 0;
      bypass   = 1'b0;
`ifdef MUL8_ZERO_BYPASS_EN
      bypass = (opA == 8'd0) || (opB == 8'd0);
`endif
      checkOutput("in_ready_before_accept", in_ready, 1);
      a         = opA;
      b         = opB;
      in_valid  = 1'b1;
      out_ready = (holdCycles == 0);
      tick();
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      checkOutput("busy_after_accept", busy, 1);
      checkOutput("in_ready_after_accept", in_ready, 0);
      if (bypass) begin
         tick();
      end else begin
         for (int s = 0; s < 4; s++) begin
            tick();
            an = stepAHi[s] ? int'(opA) / 16 : int'(opA) % 16;
            bn = stepBHi[s] ? int'(opB) / 16 : int'(opB) % 16;
            accModel = accModel + (an * bn) * (2 ** stepShift[s]);
            checkOutput($sformatf("acc_step%0d", s), dut.r_acc, accModel);
            if (s < 3) checkOutput($sformatf("out_valid_early_step%0d", s), out_valid, 0);
         end
      end
      checkOutput("out_valid_done", out_valid, 1);
      checkOutput($sformatf("product_%0h_x_%0h", opA, opB), p, product);
      for (int h = 0; h < holdCycles; h++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         a         = 8'($urandom);
         b         = 8'($urandom);
         tick();
         checkOutput("out_valid_held", out_valid, 1);
         checkOutput("p_held", p, product);
         checkOutput("in_ready_held", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("out_valid_retired", out_valid, 0);
      checkOutput("in_ready_retired", in_ready, 1);
      checkOutput("busy_retired", busy, 0);
      checkOutput("p_hold_after_retire", p, product);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'd0;
      b         = 8'd0;

      // Reset held for three cycles, then idle with no requests.
      repeat (3) tick();
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_p", p, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      repeat (3) begin
         out_ready = 1'($urandom);
         tick();
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_out_valid", out_valid, 0);
      end
      out_ready = 1'b0;

      applyStimulus(8'hFF, 8'hFF, 0);
      applyStimulus(8'h3C, 8'hA5, 10);
      applyStimulus(8'h12, 8'h34, 1);
      applyStimulus(8'hF0, 8'h0F, 0);
      applyStimulus(8'h00, 8'h77, 0);
      applyStimulus(8'h77, 8'h00, 2);

      // Abort mid-calculation: reset takes effect without a clock edge.
      a        = 8'h80;
      b        = 8'h80;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_p", p, 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("abort_no_valid", out_valid, 0);
      applyStimulus(8'd2, 8'd3, 0);

      for (int n = 0; n < 20; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 7) == 0) ra = 8'd0;
         applyStimulus(ra, rb, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
